bitwise_logic_unit_div: RTL and testbench
=========================================

Name: bitwise_logic_unit_div

Overview:
- Registered, parametrised bitwise logic unit.
- Executes one of eight bitwise operations on two WIDTH-bit operands, paced by an internal divide-by-DIV clock-enable.
- Generalises the fixed 4-bit registered XOR stage: selectable operation, configurable width and divide ratio, valid/ready input handshake, one-deep operand holding register, parity output.
- Sits in the frequency-divider datapath; consumers sample z on out_valid.

Parameters:
- WIDTH, 8: operand and result width in bits, >= 1.
- DIV, 8: divide ratio; tick asserts once every DIV enabled clk cycles, >= 1.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  block enable; low clears divider, holding register and outputs.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept operands this cycle.
- op  input  3  operation select, captured with operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- z  output  WIDTH  registered result.
- parity  output  1  XOR-reduction of z, registered with z.
- out_valid  output  1  one-cycle pulse when z/parity updated.
- tick  output  1  divider strobe, combinational from counter.

Behaviour:
- Reset (rst=0 at an edge):
  - Divider counter cnt=0, hold_full=0.
  - z=0, parity=0, out_valid=0.
  - in_ready is 0 while rst=0.
  - rst has priority over en.
- Divider:
  - cnt is ceil(log2(DIV)) bits, minimum 1.
  - When en=1, cnt increments each cycle and wraps from DIV-1 to 0.
  - tick = en && (cnt==DIV-1).
  - DIV=1: tick=en every cycle.
- Enable low (en=0, rst=1):
  - Next edge: cnt=0, hold_full=0 (pending operands discarded), z=0, parity=0, out_valid=0.
  - in_ready=0.
- Handshake:
  - in_ready = rst && en && (!hold_full || tick).
  - Capture occurs when in_valid && in_ready. a, b and op load into the holding register and hold_full is set.
  - in_valid without in_ready is ignored; the source must hold its data.
- Execute:
  - At an edge with tick=1 and hold_full=1: z <= f(op, a_h, b_h); parity <= ^f(op, a_h, b_h); out_valid <= 1.
  - hold_full is cleared, unless a capture happens in the same cycle, in which case it stays 1 with the new data.
  - tick=1 with hold_full=0: out_valid <= 0; z and parity hold.
  - Non-tick cycles: out_valid <= 0; z and parity hold.
- Operations (op): 0 XOR, 1 AND, 2 OR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT A, 7 PASS A. All full WIDTH, no carries.
- Latency:
  - Data captured at edge k is executed at the first tick cycle strictly after k.
  - out_valid is visible in the cycle after that tick edge, within 1..DIV cycles after capture.
- Throughput: one result per tick, sustained by a same-cycle capture on the tick.
- Mid-operation events:
  - Reset or en deassert with hold_full=1 discards the operands; no out_valid follows.
  - en reasserted: counting restarts from cnt=0.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, en=1 -> z=0x00, parity=0, out_valid=0, in_ready=0. After rst=1: in_ready=1, tick first at the 8th enabled cycle.
- XOR, WIDTH=8, DIV=8: capture a=0xA5, b=0x0F, op=0 at cnt=0 -> out_valid pulse 8 cycles later, z=0xAA, parity=0. z holds 0xAA afterwards with out_valid=0.
- Op sweep, a=0xC3, b=0x5A, op 0..7 -> z = 0x99, 0x42, 0xDB, 0x66, 0xBD, 0x24, 0x3C, 0xC3; parity = 0, 0, 0, 0, 0, 0, 0, 0.
- Back-pressure: in_valid held high with a=0x01, b=0x03, op=2 -> in_ready drops after capture and rises only on the tick cycle. Exactly one out_valid per tick, z=0x03, parity=0.
- Enable drop mid-operation: capture a=0xFF, b=0x00, op=0, then en=0 at cnt=3 -> next cycle z=0, out_valid=0, in_ready=0. en=1 -> no stale result; new capture completes normally.
- DIV=1, WIDTH=4: stream (a, b, op) = (0x3, 0x5, 0), (0xF, 0x1, 1), (0x0, 0x0, 5) back-to-back with in_valid=1 -> in_ready stays 1, out_valid high 3 consecutive cycles starting 2 cycles after the first capture, z = 0x6, 0x1, 0xF, parity = 0, 1, 0.

Source files
------------

// File: rtl/bitwise_logic_unit_div_if.sv
// ---------------------------------------------------------------------------
// bitwise_logic_unit_div_if
// Operand/result bundle for bitwise_logic_unit_div.
//   in_valid  source presents a, b, op
//   in_ready  unit can take operands this cycle
//   op        operation select (3 bits)
//   a, b      WIDTH-bit operands
//   z         registered WIDTH-bit result
//   parity    XOR-reduction of z, registered with z
//   out_valid one-cycle pulse when z/parity were updated
//   tick      divider strobe
// master = operand source / result consumer, slave = the unit itself.
// ---------------------------------------------------------------------------
interface bitwise_logic_unit_div_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] z;
    logic             parity;
    logic             out_valid;
    logic             tick;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, z, parity, out_valid, tick
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, z, parity, out_valid, tick
    );
endinterface

// File: rtl/bitwise_logic_unit_div.sv
// ---------------------------------------------------------------------------
// bitwise_logic_unit_div
// Registered bitwise logic unit paced by an internal divide-by-DIV strobe.
// Operands are accepted over a valid/ready handshake into a one-deep holding
// register and executed on the next divider tick.
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   en   block enable; low clears divider, holding register and outputs
//   bus  slave side of bitwise_logic_unit_div_if (handshake, operands,
//        result, parity, out_valid, tick)
// Operations: 0 XOR, 1 AND, 2 OR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT A, 7 PASS A.
// ---------------------------------------------------------------------------
module bitwise_logic_unit_div #(
    parameter int WIDTH = 8,
    parameter int DIV   = 8
) (
    input logic                    clk,
    input logic                    rst,
    input logic                    en,
    bitwise_logic_unit_div_if.slave bus
);
    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0]    cnt;
    logic             hold_full;
    logic [WIDTH-1:0] a_h;
    logic [WIDTH-1:0] b_h;
    logic [2:0]       op_h;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] z_q;
    logic             parity_q;
    logic             out_valid_q;
    logic             tick;
    logic             capture;

    // Strobe is qualified by en only, so with DIV=1 it simply follows en.
    assign tick    = en && (cnt == LAST);

    // A full holder can still accept on a tick: the old operands leave for
    // execution on the same edge, which sustains one result per tick.
    assign bus.in_ready = rst && en && (!hold_full || tick);
    assign capture      = bus.in_valid && bus.in_ready;

    // Result of the held operation.
    always_comb begin
        res = a_h;
        case (op_h)
            3'd0:    res = a_h ^ b_h;
            3'd1:    res = a_h & b_h;
            3'd2:    res = a_h | b_h;
            3'd3:    res = ~(a_h ^ b_h);
            3'd4:    res = ~(a_h & b_h);
            3'd5:    res = ~(a_h | b_h);
            3'd6:    res = ~a_h;
            default: res = a_h;
        endcase
    end

    // Divider, holding register and result registers. Reset and a dropped
    // enable both discard pending operands so no stale result can appear.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            cnt         <= '0;
            hold_full   <= 1'b0;
            a_h         <= '0;
            b_h         <= '0;
            op_h        <= 3'd0;
            z_q         <= '0;
            parity_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;

            if (tick && hold_full) begin
                z_q         <= res;
                parity_q    <= ^res;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end

            if (capture) begin
                a_h       <= bus.a;
                b_h       <= bus.b;
                op_h      <= bus.op;
                hold_full <= 1'b1;
            end else if (tick) begin
                hold_full <= 1'b0;
            end
        end
    end

    assign bus.z         = z_q;
    assign bus.parity    = parity_q;
    assign bus.out_valid = out_valid_q;
    assign bus.tick      = tick;
endmodule

// File: tb/tb_bitwise_logic_unit_div.sv
// ---------------------------------------------------------------------------
// tb_bitwise_logic_unit_div
// Self-checking bench: a WIDTH=8/DIV=8 unit driven by directed and random
// stimulus against a behavioural model, and a WIDTH=4/DIV=1 unit fed a
// back-to-back stream.
// ---------------------------------------------------------------------------
module tb_bitwise_logic_unit_div;
    localparam int W0 = 8;
    localparam int D0 = 8;
    localparam int W1 = 4;
    localparam int D1 = 1;

    logic clk = 1'b0;
    logic rst;
    logic en0;
    logic en1;

    bitwise_logic_unit_div_if #(.WIDTH(W0)) bus0 ();
    bitwise_logic_unit_div_if #(.WIDTH(W1)) bus1 ();

    bitwise_logic_unit_div #(.WIDTH(W0), .DIV(D0)) dut0 (
        .clk (clk),
        .rst (rst),
        .en  (en0),
        .bus (bus0)
    );

    bitwise_logic_unit_div #(.WIDTH(W1), .DIV(D1)) dut1 (
        .clk (clk),
        .rst (rst),
        .en  (en1),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Behavioural model of dut0: enabled-cycle count, pending operands, outputs.
    int m_count = 0;
    bit m_full  = 1'b0;
    int m_a = 0, m_b = 0, m_op = 0, m_z = 0;
    bit m_par = 1'b0, m_ov = 1'b0;
    bit last_capture = 1'b0;
    bit obs_tick = 1'b0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic int refOp(input int op, input int a, input int b, input int w);
        int mask = (1 << w) - 1;
        int r;
        case (op)
            0:       r = a ^ b;
            1:       r = a & b;
            2:       r = a | b;
            3:       r = ~(a ^ b);
            4:       r = ~(a & b);
            5:       r = ~(a | b);
            6:       r = ~a;
            default: r = a;
        endcase
        return r & mask;
    endfunction

    // One clock cycle on dut0: drive inputs, check strobe and handshake,
    // advance the model across the edge, then check registered outputs.
    task automatic applyStimulus(input bit r, input bit e, input bit v,
                                 input int a, input int b, input int op);
        bit exp_tick, exp_ready;
        rst            = r;
        en0            = e;
        bus0.in_valid  = v;
        bus0.a         = a[W0-1:0];
        bus0.b         = b[W0-1:0];
        bus0.op        = op[2:0];
        #1;
        exp_tick  = e && ((m_count % D0) == D0 - 1);
        exp_ready = r && e && (!m_full || exp_tick);
        obs_tick  = bus0.tick;
        checkOutput("tick", bus0.tick, exp_tick);
        checkOutput("in_ready", bus0.in_ready, exp_ready);
        last_capture = v && exp_ready;
        @(posedge clk);
        if (!r || !e) begin
            m_count = 0; m_full = 0; m_z = 0; m_par = 0; m_ov = 0;
        end else begin
            if (exp_tick && m_full) begin
                m_z   = refOp(m_op, m_a, m_b, W0);
                m_par = ($countones(m_z) % 2) == 1;
                m_ov  = 1;
            end else begin
                m_ov = 0;
            end
            if (last_capture) begin
                m_a = a & 'hFF; m_b = b & 'hFF; m_op = op & 7; m_full = 1;
            end else if (exp_tick) begin
                m_full = 0;
            end
            m_count++;
        end
        #1;
        checkOutput("z", bus0.z, m_z);
        checkOutput("parity", bus0.parity, m_par);
        checkOutput("out_valid", bus0.out_valid, m_ov);
    endtask

    task automatic stepIdle();
        applyStimulus(1, 1, 0, 0, 0, 0);
    endtask

    // Holds operands valid until the unit accepts them.
    task automatic sendOp(input int a, input int b, input int op);
        int n = 0;
        applyStimulus(1, 1, 1, a, b, op);
        while (!last_capture && n < 2 * D0 + 2) begin
            applyStimulus(1, 1, 1, a, b, op);
            n++;
        end
        checkOutput("send_accepted", last_capture, 1);
    endtask

    // Idles until a result pulse appears, then checks it against constants.
    task automatic waitResult(input string tag, input int exp_z, input int exp_p,
                              output int lat);
        lat = 0;
        while (!bus0.out_valid && lat < 2 * D0 + 2) begin
            stepIdle();
            lat++;
        end
        checkOutput({tag, "_valid"}, bus0.out_valid, 1);
        checkOutput({tag, "_z"}, bus0.z, exp_z);
        checkOutput({tag, "_parity"}, bus0.parity, exp_p);
    endtask

    int sweep_z[8] = '{'h99, 'h42, 'hDB, 'h66, 'hBD, 'h24, 'h3C, 'hC3};
    int s_a[5]     = '{'h3, 'hF, 'h0, 0, 0};
    int s_b[5]     = '{'h5, 'h1, 'h0, 0, 0};
    int s_op[5]    = '{0, 1, 5, 0, 0};
    int s_z[5]     = '{0, 'h6, 'h1, 'hF, 'hF};
    int s_p[5]     = '{0, 0, 1, 0, 0};

    initial begin
        int first_tick;
        int lat;
        int pulses;
        int n;

        rst = 0; en0 = 0; en1 = 0;
        bus0.in_valid = 0; bus0.a = 0; bus0.b = 0; bus0.op = 0;
        bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.op = 0;
        @(posedge clk);
        #1;

        // Reset held with enable high.
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("rst_z", bus0.z, 0);
        checkOutput("rst_parity", bus0.parity, 0);
        checkOutput("rst_out_valid", bus0.out_valid, 0);
        checkOutput("rst_in_ready", bus0.in_ready, 0);

        // First tick after release.
        first_tick = 0;
        for (int i = 1; i <= D0; i++) begin
            stepIdle();
            if (obs_tick && first_tick == 0) first_tick = i;
        end
        checkOutput("first_tick_cycle", first_tick, D0);

        // XOR captured at cnt=0.
        sendOp('hA5, 'h0F, 0);
        waitResult("xor", 'hAA, 0, lat);
        checkOutput("xor_latency", lat, D0 - 1);
        stepIdle();
        checkOutput("xor_hold_z", bus0.z, 'hAA);
        checkOutput("xor_hold_valid", bus0.out_valid, 0);

        // Operation sweep.
        for (int i = 0; i < 8; i++) begin
            sendOp('hC3, 'h5A, i);
            waitResult($sformatf("op%0d", i), sweep_z[i], 0, lat);
        end

        // Back-pressure with in_valid held high.
        pulses = 0;
        for (int i = 0; i < 3 * D0; i++) begin
            applyStimulus(1, 1, 1, 'h01, 'h03, 2);
            if (bus0.out_valid) begin
                pulses++;
                checkOutput("bp_z", bus0.z, 'h03);
            end
        end
        checkOutput("bp_pulses_ge2", pulses >= 2, 1);
        repeat (2 * D0) stepIdle();

        // Enable drop with operands pending at cnt=3.
        n = 0;
        while ((m_count % D0) != 0 && n < 2 * D0) begin
            stepIdle();
            n++;
        end
        sendOp('hFF, 'h00, 0);
        stepIdle();
        stepIdle();
        checkOutput("drop_at_cnt3", m_count % D0, 3);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("drop_z", bus0.z, 0);
        checkOutput("drop_valid", bus0.out_valid, 0);
        checkOutput("drop_in_ready", bus0.in_ready, 0);
        pulses = 0;
        for (int i = 0; i < 2 * D0; i++) begin
            stepIdle();
            if (bus0.out_valid) pulses++;
        end
        checkOutput("drop_no_stale", pulses, 0);
        sendOp('h12, 'h34, 1);
        waitResult("after_drop", 'h10, 1, lat);

        // Randomized traffic including occasional reset and enable drops.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) >= 3, $urandom_range(0, 99) >= 8,
                          $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
        end

        // DIV=1, WIDTH=4 back-to-back stream.
        rst = 1; en0 = 0; en1 = 1;
        for (int i = 0; i < 5; i++) begin
            bus1.in_valid = (i < 3);
            bus1.a        = s_a[i][W1-1:0];
            bus1.b        = s_b[i][W1-1:0];
            bus1.op       = s_op[i][2:0];
            #1;
            checkOutput($sformatf("d1_in_ready%0d", i), bus1.in_ready, 1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("d1_valid%0d", i), bus1.out_valid, (i >= 1 && i <= 3));
            checkOutput($sformatf("d1_z%0d", i), bus1.z, s_z[i]);
            checkOutput($sformatf("d1_parity%0d", i), bus1.parity, s_p[i]);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
